// File: rtl/seg_disp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_disp_if : request/data/grant and display bundle for seg_disp_arbiter  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface seg_disp_if;
  logic        req_a;
  logic [31:0] data_a;
  logic        req_b;
  logic [31:0] data_b;
  logic        gnt_a;
  logic        gnt_b;
  logic [7:0]  AN;
  logic [6:0]  Cnode;
  logic        dp;
  logic        frame_done;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  gnt_a, gnt_b, AN, Cnode, dp, frame_done
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output gnt_a, gnt_b, AN, Cnode, dp, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg_disp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_disp_arbiter : two-requester arbiter driving a scanned 8-digit display |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module seg_disp_arbiter #(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_FRAMES = 4
) (
  input wire        clk,
  input wire        rst,
  seg_disp_if.slave bus
);

  localparam int c_TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_FC_W   = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(REFRESH_DIV - 1);
  localparam logic [c_FC_W-1:0]   c_HOLD     = c_FC_W'(HOLD_FRAMES);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SHOW_A = 2'd1;
  localparam logic [1:0] c_SHOW_B = 2'd2;

  logic [1:0]          r_state, w_state_nxt;
  logic [c_TICK_W-1:0] r_tick, w_tick_nxt;
  logic [2:0]          r_idx, w_idx_nxt;
  logic [c_FC_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
  logic                r_last_b, w_last_b_nxt;
  logic [31:0]         r_data, w_data_nxt;

  logic                w_slot_end;
  logic                w_frame_end;
  logic [c_FC_W:0]     w_fc_inc;
  logic                w_hold_met;
  logic                w_load;
  logic [3:0]          w_nibble;

  logic                r_gnt_a, w_gnt_a_nxt;
  logic                r_gnt_b, w_gnt_b_nxt;
  logic [7:0]          r_an, w_an_nxt;
  logic [6:0]          r_cnode, w_cnode_nxt;
  logic                r_dp;
  logic                r_frame_done, w_frame_done_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_slot_end  = (r_state != c_IDLE) && (r_tick == c_TICK_MAX);
  assign w_frame_end = w_slot_end && (r_idx == 3'd7);
  assign w_fc_inc    = {1'b0, r_frame_cnt} + (c_FC_W + 1)'(1);
  assign w_hold_met  = (w_fc_inc >= {1'b0, c_HOLD});

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: an owner can only be displaced on a frame boundary
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (bus.req_a && (!bus.req_b || r_last_b)) begin
          w_state_nxt = c_SHOW_A;
        end else if (bus.req_b) begin
          w_state_nxt = c_SHOW_B;
        end
      end
      c_SHOW_A: begin
        if (w_frame_end) begin
          if (bus.req_b && (w_hold_met || !bus.req_a)) begin
            w_state_nxt = c_SHOW_B;
          end else if (!bus.req_a) begin
            w_state_nxt = c_IDLE;
          end
        end
      end
      c_SHOW_B: begin
        if (w_frame_end) begin
          if (bus.req_a && (w_hold_met || !bus.req_b)) begin
            w_state_nxt = c_SHOW_A;
          end else if (!bus.req_b) begin
            w_state_nxt = c_IDLE;
          end
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Scan counters run only while an owner is displayed; a switch keeps scanning
  always_comb begin
    w_tick_nxt = '0;
    w_idx_nxt  = '0;
    if ((r_state != c_IDLE) && (w_state_nxt != c_IDLE)) begin
      w_tick_nxt = w_slot_end ? '0 : r_tick + c_TICK_W'(1);
      w_idx_nxt  = w_slot_end ? r_idx + 3'd1 : r_idx;
    end

    w_frame_cnt_nxt = r_frame_cnt;
    if (w_state_nxt != r_state) begin
      w_frame_cnt_nxt = '0;
    end else if (w_frame_end && (r_frame_cnt < c_HOLD)) begin
      w_frame_cnt_nxt = r_frame_cnt + c_FC_W'(1);
    end

    w_last_b_nxt = r_last_b;
    if ((r_state != c_SHOW_A) && (w_state_nxt == c_SHOW_A)) begin
      w_last_b_nxt = 1'b0;
    end else if ((r_state != c_SHOW_B) && (w_state_nxt == c_SHOW_B)) begin
      w_last_b_nxt = 1'b1;
    end

    // Data snapshots only at grant or frame boundary so a frame never tears
    w_load     = (r_state == c_IDLE) || w_frame_end;
    w_data_nxt = r_data;
    if (w_load && (w_state_nxt == c_SHOW_A)) begin
      w_data_nxt = bus.data_a;
    end else if (w_load && (w_state_nxt == c_SHOW_B)) begin
      w_data_nxt = bus.data_b;
    end
  end

  // Output logic, evaluated on next-cycle values so outputs stay registered
  always_comb begin
    w_nibble         = w_data_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_an_nxt         = 8'hFF;
    w_cnode_nxt      = 7'h7F;
    w_gnt_a_nxt      = 1'b0;
    w_gnt_b_nxt      = 1'b0;
    w_frame_done_nxt = 1'b0;
    if (w_state_nxt != c_IDLE) begin
      w_an_nxt         = ~(8'b1 << w_idx_nxt);
      w_cnode_nxt      = f_decode(w_nibble);
      w_gnt_a_nxt      = (w_state_nxt == c_SHOW_A);
      w_gnt_b_nxt      = (w_state_nxt == c_SHOW_B);
      w_frame_done_nxt = (w_tick_nxt == c_TICK_MAX) && (w_idx_nxt == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick       <= '0;
      r_idx        <= '0;
      r_frame_cnt  <= '0;
      r_last_b     <= 1'b1;
      r_data       <= '0;
      r_gnt_a      <= 1'b0;
      r_gnt_b      <= 1'b0;
      r_an         <= 8'hFF;
      r_cnode      <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_tick       <= w_tick_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_last_b     <= w_last_b_nxt;
      r_data       <= w_data_nxt;
      r_gnt_a      <= w_gnt_a_nxt;
      r_gnt_b      <= w_gnt_b_nxt;
      r_an         <= w_an_nxt;
      r_cnode      <= w_cnode_nxt;
      r_dp         <= 1'b1;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.gnt_a      = r_gnt_a;
  assign bus.gnt_b      = r_gnt_b;
  assign bus.AN         = r_an;
  assign bus.Cnode      = r_cnode;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_disp_arbiter : directed and random checks of seg_disp_arbiter      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_seg_disp_arbiter;
  localparam int DIV   = 4;
  localparam int HOLD  = 2;
  localparam int FRAME = 8 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  seg_disp_if bus();

  seg_disp_arbiter #(.REFRESH_DIV(DIV), .HOLD_FRAMES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: owner (0 none, 1 A, 2 B), cycle position within frame, frames served
  int          m_owner  = 0;
  int          m_pos    = 0;
  int          m_frames = 0;
  bit          m_last_b = 1'b1;
  logic [31:0] m_held   = '0;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic take(input int id);
    m_owner  = id;
    m_pos    = 0;
    m_frames = 0;
    m_last_b = (id == 2);
    m_held   = (id == 1) ? bus.data_a : bus.data_b;
  endtask

  task automatic model_step();
    bit mine, other;
    if (rst) begin
      m_owner = 0; m_pos = 0; m_frames = 0; m_last_b = 1'b1; m_held = '0;
    end else if (m_owner == 0) begin
      if (bus.req_a && (!bus.req_b || m_last_b)) take(1);
      else if (bus.req_b) take(2);
    end else if (m_pos == FRAME - 1) begin
      mine  = (m_owner == 1) ? bus.req_a : bus.req_b;
      other = (m_owner == 1) ? bus.req_b : bus.req_a;
      m_frames++;
      if (other && (m_frames >= HOLD || !mine)) begin
        take(3 - m_owner);
      end else if (!mine) begin
        m_owner = 0; m_pos = 0; m_frames = 0;
      end else begin
        m_pos  = 0;
        m_held = (m_owner == 1) ? bus.data_a : bus.data_b;
      end
    end else begin
      m_pos++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle, mid-way between active edges
  initial forever begin
    logic [7:0] e_an;
    logic [6:0] e_cn;
    logic [1:0] e_g;
    logic       e_fd;
    int         idx;
    logic [31:0] sh;
    @(negedge clk);
    e_an = 8'hFF; e_cn = 7'h7F; e_g = 2'b00; e_fd = 1'b0;
    if (m_owner != 0) begin
      idx  = m_pos / DIV;
      sh   = m_held >> (4 * idx);
      e_an = ~(8'b1 << idx);
      e_cn = seg_tab[sh[3:0]];
      e_g  = (m_owner == 1) ? 2'b10 : 2'b01;
      e_fd = (m_pos == FRAME - 1);
    end
    chk("AN", bus.AN, e_an);
    chk("Cnode", bus.Cnode, e_cn);
    chk("gnt_ab", {bus.gnt_a, bus.gnt_b}, e_g);
    chk("dp", bus.dp, 1'b1);
    chk("frame_done", bus.frame_done, e_fd);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus.data_a = '0;  bus.data_b = '0;
    rst = 1'b1;
    cyc(3);
    chk("lit_rst_AN", bus.AN, 8'hFF);
    chk("lit_rst_Cnode", bus.Cnode, 7'h7F);
    chk("lit_rst_gnt", {bus.gnt_a, bus.gnt_b}, 2'b00);
    chk("lit_rst_fd", bus.frame_done, 1'b0);
    rst = 1'b0; bus.req_a = 1'b1; bus.data_a = 32'h4;
    cyc(1);
    chk("lit_grant_gnt_a", bus.gnt_a, 1'b1);
    chk("lit_grant_AN", bus.AN, 8'hFE);
    chk("lit_grant_Cnode", bus.Cnode, 7'h19);
    cyc(4);
    chk("lit_d1_AN", bus.AN, 8'hFD);
    chk("lit_d1_Cnode", bus.Cnode, 7'h40);
    cyc(27);
    chk("lit_fd1", bus.frame_done, 1'b1);
    chk("lit_d7_AN", bus.AN, 8'h7F);
    cyc(1);
    chk("lit_wrap_AN", bus.AN, 8'hFE);
    chk("lit_fd1_off", bus.frame_done, 1'b0);
    bus.req_b = 1'b1; bus.data_b = 32'hABCD_EF0B;
    cyc(31);
    chk("lit_fd2", bus.frame_done, 1'b1);
    chk("lit_fd2_gnt", {bus.gnt_a, bus.gnt_b}, 2'b10);
    cyc(1);
    chk("lit_sw_b_gnt", {bus.gnt_a, bus.gnt_b}, 2'b01);
    chk("lit_sw_b_Cnode", bus.Cnode, 7'h03);
    cyc(64);
    chk("lit_sw_a_gnt", {bus.gnt_a, bus.gnt_b}, 2'b10);
    chk("lit_sw_a_Cnode", bus.Cnode, 7'h19);
    bus.req_b = 1'b0;
    cyc(11);
    bus.data_a = 32'hFFFF_FFFF;
    cyc(1);
    chk("lit_notear_Cnode", bus.Cnode, 7'h40);
    cyc(20);
    chk("lit_newframe_AN", bus.AN, 8'hFE);
    chk("lit_newframe_Cnode", bus.Cnode, 7'h0E);
    cyc(9);
    bus.req_a = 1'b0;
    cyc(22);
    chk("lit_rel_last_AN", bus.AN, 8'h7F);
    chk("lit_rel_last_gnt", bus.gnt_a, 1'b1);
    cyc(1);
    chk("lit_rel_AN", bus.AN, 8'hFF);
    chk("lit_rel_Cnode", bus.Cnode, 7'h7F);
    chk("lit_rel_gnt", {bus.gnt_a, bus.gnt_b}, 2'b00);
    bus.req_b = 1'b1;
    cyc(1);
    chk("lit_b_gnt", bus.gnt_b, 1'b1);
    cyc(21);
    chk("lit_idx5_AN", bus.AN, 8'hDF);
    rst = 1'b1;
    cyc(1);
    chk("lit_midrst_AN", bus.AN, 8'hFF);
    chk("lit_midrst_gnt", {bus.gnt_a, bus.gnt_b}, 2'b00);
    rst = 1'b0;
    cyc(1);
    chk("lit_postrst_gnt_b", bus.gnt_b, 1'b1);
    chk("lit_postrst_AN", bus.AN, 8'hFE);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(39) == 0) bus.req_a = ~bus.req_a;
      if ($urandom_range(39) == 0) bus.req_b = ~bus.req_b;
      if ($urandom_range(7) == 0)  bus.data_a = $urandom;
      if ($urandom_range(7) == 0)  bus.data_b = $urandom;
      rst = ($urandom_range(599) == 0);
    end
    rst = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
